// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon128/128 CBC controller and its core.
package simon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    OUT    = 2'd3
  } cbc_state_t;

  localparam int SIMON_BLK_W    = 128;
  localparam int SIMON_CORE_LAT = 70;
  // Load cycle and valid-set cycle bracket the round iterations.
  localparam int SIMON_ROUNDS   = SIMON_CORE_LAT - 2;

  // Constant sequence z2; sequence bit i is SIMON_Z2[61-i].
  localparam logic [61:0] SIMON_Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  function automatic logic [63:0] simon_f(input logic [63:0] x);
    return ({x[62:0], x[63]} & {x[55:0], x[63:56]}) ^ {x[61:0], x[63:62]};
  endfunction

endpackage

// File: rtl/simon_cbc_ctrl_core.sv
// Iterative Simon128/128 encryption core (top_simon): one round per cycle with
// on-the-fly key expansion; valid rises SIMON_CORE_LAT cycles after start.
module top_simon
  import simon_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] pt_i,
  output logic         valid_o,
  output logic [127:0] ct_o
);

  logic [63:0] x_q, x_d, y_q, y_d, ka_q, ka_d, kb_q, kb_d;
  logic [6:0]  rnd_q, rnd_d;
  logic        run_q, run_d, valid_q, valid_d;
  logic [5:0]  z_idx;
  logic [63:0] kt_r3, kt;

  always_comb begin
    z_idx   = (rnd_q >= 7'd62) ? 6'(rnd_q - 7'd62) : rnd_q[5:0];
    kt_r3   = {kb_q[2:0], kb_q[63:3]};
    kt      = kt_r3 ^ {kt_r3[0], kt_r3[63:1]};
    x_d     = x_q;
    y_d     = y_q;
    ka_d    = ka_q;
    kb_d    = kb_q;
    rnd_d   = rnd_q;
    run_d   = run_q;
    valid_d = valid_q;
    if (start_i) begin
      x_d     = pt_i[127:64];
      y_d     = pt_i[63:0];
      ka_d    = key_i[63:0];
      kb_d    = key_i[127:64];
      rnd_d   = 7'd0;
      run_d   = 1'b1;
      valid_d = 1'b0;
    end else if (run_q) begin
      if (rnd_q != 7'(SIMON_ROUNDS)) begin
        x_d   = y_q ^ simon_f(x_q) ^ ka_q;
        y_d   = x_q;
        ka_d  = kb_q;
        // ~k ^ 3 ^ z folded into one constant: all ones above bit 1, z in bit 0.
        kb_d  = ka_q ^ kt ^ {62'h3FFF_FFFF_FFFF_FFFF, 1'b0, SIMON_Z2[6'd61 - z_idx]};
        rnd_d = rnd_q + 7'd1;
      end else begin
        run_d   = 1'b0;
        valid_d = 1'b1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= 64'd0;
      y_q     <= 64'd0;
      ka_q    <= 64'd0;
      kb_q    <= 64'd0;
      rnd_q   <= 7'd0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      rnd_q   <= rnd_d;
      run_q   <= run_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign ct_o    = {x_q, y_q};

endmodule

// File: rtl/simon_cbc_ctrl.sv
// CBC-mode front end for top_simon: chains plaintext blocks, runs the core and
// streams ciphertext. Define SIMON_CBC_STATUS_EN to add busy_o and blk_cnt_o.
module simon_cbc_ctrl
  import simon_pkg::*;
#(
  parameter int BLK_W = 128,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load_i,
  input  logic [127:0]     key_i,
  input  logic [127:0]     iv_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [BLK_W-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BLK_W-1:0] out_data_o,
  output logic             out_last_o
`ifdef SIMON_CBC_STATUS_EN
  ,
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_cnt_o
`endif
);

  if (BLK_W != SIMON_BLK_W) begin : g_bad_blk_w
    $error("simon_cbc_ctrl: BLK_W must be 128");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("simon_cbc_ctrl: CNT_W must be at least 1");
  end

  cbc_state_t       state_q, state_d;
  logic [127:0]     key_q, key_d, iv_q, iv_d;
  logic [BLK_W-1:0] chain_q, chain_d, core_pt_q, core_pt_d, out_data_q, out_data_d;
  logic             key_loaded_q, key_loaded_d, last_q, last_d, start_q, start_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic             core_valid_q, core_valid, core_done;
  logic [127:0]     core_ct;
`ifdef SIMON_CBC_STATUS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  top_simon u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_q),
    .key_i   (key_q),
    .pt_i    (core_pt_q),
    .valid_o (core_valid),
    .ct_o    (core_ct)
  );

  assign core_done = core_valid & ~core_valid_q;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    iv_d         = iv_q;
    chain_d      = chain_q;
    core_pt_d    = core_pt_q;
    key_loaded_d = key_loaded_q;
    last_d       = last_q;
    start_d      = 1'b0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
`ifdef SIMON_CBC_STATUS_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        // A configuration load takes priority over a pending block.
        if (cfg_load_i) begin
          key_d        = key_i;
          iv_d         = iv_i;
          chain_d      = iv_i;
          key_loaded_d = 1'b1;
`ifdef SIMON_CBC_STATUS_EN
          cnt_d        = '0;
`endif
        end else if (in_valid_i && key_loaded_q) begin
          core_pt_d = in_data_i ^ chain_q;
          last_d    = in_last_i;
          start_d   = 1'b1;
          state_d   = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (core_done) begin
          out_data_d  = core_ct;
          out_last_d  = last_q;
          out_valid_d = 1'b1;
          chain_d     = last_q ? iv_q : core_ct;
          state_d     = OUT;
        end else begin
          state_d = WAIT;
        end
      end
      OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef SIMON_CBC_STATUS_EN
          cnt_d       = cnt_q + 1'b1;
`endif
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      key_q        <= 128'd0;
      iv_q         <= 128'd0;
      chain_q      <= '0;
      core_pt_q    <= '0;
      key_loaded_q <= 1'b0;
      last_q       <= 1'b0;
      start_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      core_valid_q <= 1'b0;
`ifdef SIMON_CBC_STATUS_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      iv_q         <= iv_d;
      chain_q      <= chain_d;
      core_pt_q    <= core_pt_d;
      key_loaded_q <= key_loaded_d;
      last_q       <= last_d;
      start_q      <= start_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      core_valid_q <= core_valid;
`ifdef SIMON_CBC_STATUS_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == IDLE) & key_loaded_q & ~cfg_load_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
`ifdef SIMON_CBC_STATUS_EN
  assign busy_o      = (state_q != IDLE);
  assign blk_cnt_o   = cnt_q;
`endif

endmodule

// File: tb/tb_simon_cbc_ctrl.sv
// Scoreboard bench for simon_cbc_ctrl: the driver queues expected ciphertext,
// a monitor checks every delivered block, latency and stall behaviour.
module tb_simon_cbc_ctrl;

  localparam logic [127:0] KEY1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PT   = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] KAT  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
  localparam logic [127:0] KEY2 = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] IV2  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] KEY3 = 128'hdeadbeefcafef00d0badc0de55aa33cc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_load_i = 1'b0;
  logic [127:0] key_i = 128'd0, iv_i = 128'd0, in_data_i = 128'd0;
  logic         in_valid_i = 1'b0, in_last_i = 1'b0, out_ready_i = 1'b1;
  logic         in_ready_o, out_valid_o, out_last_o;
  logic [127:0] out_data_o;
`ifdef SIMON_CBC_STATUS_EN
  logic         busy_o;
  logic [31:0]  blk_cnt_o;
`endif

  simon_cbc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_load_i(cfg_load_i), .key_i(key_i), .iv_i(iv_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_last_i(in_last_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o)
`ifdef SIMON_CBC_STATUS_EN
    , .busy_o(busy_o), .blk_cnt_o(blk_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic         l;
    int           hs;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   loaded_tb = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Independent reference: full key expansion first, then 68 rounds.
  function automatic logic [127:0] simon_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [63:0] k[68];
    logic [63:0] x, y, t;
    logic [61:0] z;
    int          zi;
    z = 62'b10101111011100000011010010011000101000010001111110010110110011;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 2; i < 68; i++) begin
      t  = (k[i-1] >> 3) | (k[i-1] << 61);
      t  = t ^ ((t >> 1) | (t << 63));
      zi = 61 - ((i - 2) % 62);
      k[i] = ~k[i-2] ^ t ^ 64'd3 ^ {63'd0, z[zi]};
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      t = x;
      x = y ^ (((x << 1) | (x >> 63)) & ((x << 8) | (x >> 56))) ^ ((x << 2) | (x >> 62)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic cfg_load(input logic [127:0] k, input logic [127:0] iv);
    @(negedge clk);
    key_i = k; iv_i = iv; cfg_load_i = 1'b1;
    @(negedge clk);
    cfg_load_i = 1'b0;
    loaded_tb = 1'b1;
  endtask

  task automatic send(input logic [127:0] pt, input logic last, input logic [127:0] exp_d);
    int n = 0;
    @(negedge clk);
    in_data_i = pt; in_last_i = last; in_valid_i = 1'b1;
    #1;
    while (!in_ready_o && n < 1000) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready_o) begin
      chk("accept_timeout", 128'(in_ready_o), 128'd1);
    end else begin
      sb_q.push_back('{d: exp_d, l: last, hs: cyc});
    end
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || out_valid_o) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk(name, 128'(sb_q.size()), 128'd0);
  endtask

  // Monitor: compares every delivered block against the scoreboard head.
  initial begin : monitor
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        if (out_valid_o && !prev_v && sb_q.size() != 0)
          chk("latency", 128'(cyc - sb_q[0].hs), 128'd72);
        if (out_valid_o) chk("ready_while_out", 128'(in_ready_o), 128'd0);
        if (out_valid_o && !out_ready_i && sb_q.size() != 0)
          chk("stall_data", out_data_o, sb_q[0].d);
`ifdef SIMON_CBC_STATUS_EN
        if (loaded_tb && !cfg_load_i) chk("busy", 128'(busy_o), 128'(!in_ready_o));
`endif
        if (out_valid_o && out_ready_i) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_out", out_data_o, 128'hx);
          end else begin
            e = sb_q.pop_front();
            chk("ct", out_data_o, e.d);
            chk("last", 128'(out_last_o), 128'(e.l));
          end
        end
      end
      prev_v = out_valid_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    #12;
    chk("rst_in_ready", 128'(in_ready_o), 128'd0);
    chk("rst_out_valid", 128'(out_valid_o), 128'd0);
    chk("rst_out_data", out_data_o, 128'd0);
    chk("rst_out_last", 128'(out_last_o), 128'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); in_valid_i = 1'b1; #1;
    chk("ready_before_cfg", 128'(in_ready_o), 128'd0);
    in_valid_i = 1'b0;

    // T1: known-answer block
    cfg_load(KEY1, 128'd0);
    #1 chk("ready_after_cfg", 128'(in_ready_o), 128'd1);
    send(PT, 1'b1, KAT);
    drain("t1_drain");

    // T2: chained blocks, then the chain returns to the IV
    send(PT, 1'b0, KAT);
    send(PT, 1'b1, simon_ref(KEY1, PT ^ KAT));
    send(PT, 1'b1, KAT);
    drain("t2_drain");

    // T3: sink stalled for 200 cycles
    @(negedge clk); out_ready_i = 1'b0;
    send(PT, 1'b1, KAT);
    repeat (200) @(negedge clk);
    out_ready_i = 1'b1;
    drain("t3_drain");

    // T4: cfg_load in WAIT is ignored; cfg_load with in_valid in IDLE wins
    send(PT, 1'b1, KAT);
    repeat (20) @(negedge clk);
    key_i = KEY3; iv_i = IV2; cfg_load_i = 1'b1;
    @(negedge clk); cfg_load_i = 1'b0;
    drain("t4a_drain");
    @(negedge clk);
    key_i = KEY2; iv_i = IV2; cfg_load_i = 1'b1; in_valid_i = 1'b1; in_data_i = PT; in_last_i = 1'b1;
    #1 chk("cfg_gates_ready", 128'(in_ready_o), 128'd0);
    @(negedge clk); cfg_load_i = 1'b0; in_valid_i = 1'b0;
    #1 chk("no_accept_on_cfg", 128'(in_ready_o), 128'd1);
    send(PT, 1'b1, simon_ref(KEY2, PT ^ IV2));
    drain("t4b_drain");

    // T5: reset during WAIT aborts the block
    cfg_load(KEY1, 128'd0);
    send(PT, 1'b1, KAT);
    repeat (29) @(negedge clk);
    rst_n = 1'b0; loaded_tb = 1'b0;
    #1;
    sb_q.delete();
    chk("t5_out_valid", 128'(out_valid_o), 128'd0);
    chk("t5_out_data", out_data_o, 128'd0);
    chk("t5_in_ready", 128'(in_ready_o), 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    #1 chk("t5_no_output", 128'(out_valid_o), 128'd0);
    chk("t5_ready_unloaded", 128'(in_ready_o), 128'd0);
    cfg_load(KEY1, 128'd0);
    send(PT, 1'b1, KAT);
    drain("t5_drain");

`ifdef SIMON_CBC_STATUS_EN
    // T6: delivered-block counter
    chk("t6_cnt_one", 128'(blk_cnt_o), 128'd1);
    cfg_load(KEY1, 128'd0);
    chk("t6_cnt_clear", 128'(blk_cnt_o), 128'd0);
    for (int i = 0; i < 3; i++) send(PT, 1'b1, KAT);
    drain("t6_drain");
    chk("t6_cnt_three", 128'(blk_cnt_o), 128'd3);
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
